// File: rtl/axi_slave_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_pkg
// Brief  : Shared types for the AXI4-Lite register slave: response codes
//          and the transaction FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    R_ADDR = 3'd4,
    R_DATA = 3'd5
  } state_t;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_slave_lite_if.sv
`default_nettype none
// ============================================================================
// Module : axi_slave_lite_if
// Brief  : AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave
//          views.
// Rev    : 1.0  initial release
// ============================================================================
interface axi_slave_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  awvalid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awready;
  logic                  wvalid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wready;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arready;
  logic                  rready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bresp, bvalid, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bresp, bvalid, arready, rvalid, rdata, rresp
  );

endinterface : axi_slave_lite_if
`default_nettype wire

// File: rtl/axi_slave_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_regfile
// Brief  : NUM_REGS x DATA_WIDTH register array with one byte-strobed write
//          port and one combinational read port; cleared by reset.
// Rev    : 1.0  initial release
// ============================================================================
module axi_lite_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_we,
  input  wire logic [IDX_WIDTH-1:0]  i_widx,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  input  wire logic [STRB_WIDTH-1:0] i_wstrb,
  input  wire logic [IDX_WIDTH-1:0]  i_ridx,
  output logic      [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Storage: clear on reset, otherwise update only the enabled byte lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) begin
          r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // The caller only uses this value when the index is in range.
  assign o_rdata = r_regs[i_ridx];

endmodule : axi_lite_regfile
`default_nettype wire

// File: rtl/axi_slave_lite.sv
`default_nettype none
// ============================================================================
// Module : axi_slave_lite
// Brief  : AXI4-Lite slave fronting a word-indexed register window at
//          BASE_ADDR. One transaction at a time; a write wins over a read.
// Rev    : 1.0  initial release
// ============================================================================
module axi_slave_lite
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_0000
) (
  input wire logic          aclk,
  input wire logic          arst,
  axi_slave_lite_if.slave   bus
);

  localparam int                    IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_num_regs = ADDR_WIDTH'(NUM_REGS);

  state_t r_state, w_state_nxt;

  logic                  r_awready, w_awready_nxt;
  logic                  r_wready,  w_wready_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_bvalid,  w_bvalid_nxt;
  resp_t                 r_bresp,   w_bresp_nxt;
  logic                  r_rvalid,  w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;
  resp_t                 r_rresp,   w_rresp_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr,  w_awaddr_nxt;

  logic [ADDR_WIDTH-1:0] w_aw_off;
  logic [ADDR_WIDTH-1:0] w_ar_off;
  logic                  w_aw_ok;
  logic                  w_ar_ok;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rf_rdata;

  // Address decode: an address below BASE_ADDR wraps to a huge offset and
  // therefore fails the same range check as one past the window.
  assign w_aw_off = r_awaddr - BASE_ADDR;
  assign w_ar_off = bus.araddr - BASE_ADDR;
  assign w_aw_ok  = (w_aw_off < c_num_regs);
  assign w_ar_ok  = (w_ar_off < c_num_regs);

  axi_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_regfile (
    .clk     (aclk),
    .rst     (arst),
    .i_we    (w_we),
    .i_widx  (w_aw_off[IDX_WIDTH-1:0]),
    .i_wdata (bus.wdata),
    .i_wstrb (bus.wstrb),
    .i_ridx  (w_ar_off[IDX_WIDTH-1:0]),
    .o_rdata (w_rf_rdata)
  );

  // State register.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and next values of every registered output; ready strobes are
  // raised on the edge entering their state so they are high for that state.
  always_comb begin
    w_state_nxt   = r_state;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_arready_nxt = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_awaddr_nxt  = r_awaddr;
    w_we          = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.awvalid && bus.wvalid) begin
          w_state_nxt   = W_ADDR;
          w_awready_nxt = 1'b1;
        end else if (bus.arvalid) begin
          w_state_nxt   = R_ADDR;
          w_arready_nxt = 1'b1;
        end
      end
      W_ADDR: begin
        w_awaddr_nxt = bus.awaddr;
        w_state_nxt  = W_DATA;
        w_wready_nxt = 1'b1;
      end
      W_DATA: begin
        if (bus.wvalid) begin
          w_we         = w_aw_ok;
          w_bresp_nxt  = w_aw_ok ? RESP_OKAY : RESP_SLVERR;
          w_bvalid_nxt = 1'b1;
          w_state_nxt  = W_RESP;
        end else begin
          w_wready_nxt = 1'b1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_bvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      R_ADDR: begin
        w_rvalid_nxt = 1'b1;
        w_rdata_nxt  = w_ar_ok ? w_rf_rdata : '0;
        w_rresp_nxt  = w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        w_state_nxt  = R_DATA;
      end
      R_DATA: begin
        if (bus.rready) begin
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output and address registers.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_awaddr  <= '0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_arready <= w_arready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_awaddr  <= w_awaddr_nxt;
    end
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.arready = r_arready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;

endmodule : axi_slave_lite
`default_nettype wire

// File: tb/tb_axi_slave_lite.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_slave_lite
// Brief  : Self-checking bench for axi_slave_lite: directed scenarios plus
//          random traffic against an array model of the register window.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_slave_lite;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          NREG = 16;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  always #5 aclk = ~aclk;

  axi_slave_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_slave_lite #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (NREG),
    .BASE_ADDR  (BASE)
  ) dut (
    .aclk (aclk),
    .arst (arst),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [NREG];

  // Read-channel activity seen while a write is overriding a read.
  logic mon_en   = 1'b0;
  int   ovr_hits = 0;
  always @(posedge aclk) begin
    if (mon_en && (bus.arready || bus.rvalid)) ovr_hits++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
  endtask

  // Returns the expected response and applies the write to the model.
  function automatic logic [1:0] model_write(input logic [31:0] addr,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] idx;
    idx = addr - BASE;
    if (idx >= NREG) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr - BASE;
    if (idx >= NREG) return {2'b10, 32'h0};
    return {2'b00, model[idx]};
  endfunction

  task automatic wait_neg(input logic which_rd, input int sel);
    // sel: 0 awready, 1 wready, 2 bvalid (write side) / 0 arready, 1 rvalid (read side)
    int k;
    logic seen;
    k = 0;
    do begin
      @(negedge aclk);
      k++;
      if (!which_rd) seen = (sel == 0) ? bus.awready : (sel == 1) ? bus.wready : bus.bvalid;
      else           seen = (sel == 0) ? bus.arready : bus.rvalid;
    end while (!seen && k < 50);
    if (!seen) chk($sformatf("timeout_%0d_%0d", which_rd, sel), 32'(seen), 32'd1);
  endtask

  task automatic drive_idle();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    bus.bready  = 0; bus.rready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit ovr, input int bp,
                          input bit rst_in_resp);
    logic [1:0] exp_resp;
    @(negedge aclk);
    bus.awvalid = 1; bus.wvalid = 1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    if (ovr) begin bus.arvalid = 1; bus.araddr = addr; end
    wait_neg(1'b0, 0);
    @(posedge aclk); #1 bus.awvalid = 0;
    wait_neg(1'b0, 1);
    @(posedge aclk); #1 bus.wvalid = 0; bus.arvalid = 0;
    exp_resp = model_write(addr, data, strb);
    wait_neg(1'b0, 2);
    chk($sformatf("bresp@%h", addr), 32'(bus.bresp), 32'(exp_resp));
    if (rst_in_resp) begin
      arst = 1;
      #1;
      chk("rst_outputs_zero",
          32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.bresp,
               bus.rvalid, bus.rresp, |bus.rdata}), 32'd0);
      model_clear();
      @(negedge aclk); arst = 0;
      return;
    end
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin bus.arvalid = 1; bus.araddr = BASE; end
      @(negedge aclk);
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("bresp_hold", 32'(bus.bresp), 32'(exp_resp));
      chk("no_new_txn_w", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    end
    bus.arvalid = 0;
    bus.bready = 1;
    @(posedge aclk); #1 bus.bready = 0;
    chk("bvalid_drop", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int bp, output logic [31:0] got);
    logic [33:0] exp;
    exp = model_read(addr);
    @(negedge aclk);
    bus.arvalid = 1; bus.araddr = addr;
    wait_neg(1'b1, 0);
    @(posedge aclk); #1 bus.arvalid = 0;
    wait_neg(1'b1, 1);
    got = bus.rdata;
    chk($sformatf("rdata@%h", addr), bus.rdata, exp[31:0]);
    chk($sformatf("rresp@%h", addr), 32'(bus.rresp), 32'(exp[33:32]));
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin
        bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = BASE + 32'd3;
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
      end
      @(negedge aclk);
      chk("rvalid_hold", 32'(bus.rvalid), 32'd1);
      chk("rdata_hold", bus.rdata, exp[31:0]);
      chk("no_new_txn_r", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
    end
    bus.awvalid = 0; bus.wvalid = 0;
    bus.rready = 1;
    @(posedge aclk); #1 bus.rready = 0;
    chk("rvalid_drop", 32'(bus.rvalid), 32'd0);
  endtask

  logic [31:0] s1_exp [6] = '{32'h0000_0000, 32'h0000_00EF, 32'h0000_BEEF,
                              32'h00AD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
  logic [3:0]  s1_strb [6] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    drive_idle();
    bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0; bus.araddr = 0;
    model_clear();

    // Reset state
    #12;
    chk("reset_outputs",
        32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.bresp,
             bus.rvalid, bus.rresp, |bus.rdata}), 32'd0);
    @(negedge aclk); arst = 0;

    // 1. back-to-back strobed writes then reads
    for (int i = 0; i < 6; i++)
      do_write(BASE + 32'(i + 3), 32'hDEAD_BEEF, s1_strb[i], 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_read(BASE + 32'(i + 3), 0, got);
      chk($sformatf("s1_literal_%0d", i + 3), got, s1_exp[i]);
    end

    // 2. sequential write+read with rotating strobes
    for (int i = 0; i < 9; i++) begin
      logic [3:0] st;
      st = 4'(((1 << (i % 5)) - 1));
      do_write(BASE + 32'(i), 32'hDEAD_BEEF, st, 1'b0, 0, 1'b0);
      do_read(BASE + 32'(i), 0, got);
    end

    // 3. write overrides simultaneous read, from a freshly reset window
    @(negedge aclk); arst = 1; model_clear();
    @(negedge aclk); arst = 0;
    ovr_hits = 0; mon_en = 1;
    for (int i = 0; i < 6; i++)
      do_write(BASE + 32'(i + 3), 32'hDEAD_BEEF, s1_strb[i], 1'b1, 0, 1'b0);
    @(negedge aclk); mon_en = 0;
    chk("override_read_activity", 32'(ovr_hits), 32'd0);
    for (int i = 0; i < 6; i++) begin
      do_read(BASE + 32'(i + 3), 0, got);
      chk($sformatf("s3_literal_%0d", i + 3), got, s1_exp[i]);
    end

    // 4. out-of-range accesses
    do_write(BASE + 32'd16, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, 1'b0);
    do_read(BASE + 32'd16, 0, got);
    do_read(BASE - 32'd1, 0, got);
    chk("oor_below_literal", got, 32'h0);
    for (int i = 0; i < NREG; i++) do_read(BASE + 32'(i), 0, got);

    // 5. backpressure on both response channels
    do_write(BASE + 32'd10, 32'hCAFE_F00D, 4'hF, 1'b0, 5, 1'b0);
    do_read(BASE + 32'd10, 5, got);
    chk("bp_literal", got, 32'hCAFE_F00D);

    // 6. reset while the write response is pending
    do_write(BASE + 32'd3, 32'hA5A5_5A5A, 4'hF, 1'b0, 0, 1'b1);
    drive_idle();
    do_read(BASE + 32'd3, 0, got);
    chk("post_reset_literal", got, 32'h0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 4));
        1:       a = BASE + 32'($urandom_range(16, 40));
        default: a = BASE + 32'($urandom_range(0, NREG - 1));
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 1'b0);
      else
        do_read(a, $urandom_range(0, 2), got);
    end
    for (int i = 0; i < NREG; i++) do_read(BASE + 32'(i), 0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule : tb_axi_slave_lite
`default_nettype wire
